// File: rtl/sprite_layer.sv
// sprite_layer
// Compositing stage for one hardware sprite. Each active pixel is tested
// against the sprite box; on a hit the texel is fetched from sprite VRAM and,
// unless it matches the transparency key, replaces the background colour.
// Sprite position/enable are sampled once per frame so a mid-frame update by
// software never tears the image. An animation counter selects one of FRAMES
// texel pages that are stored back-to-back in VRAM.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   frame_start   : one-cycle pulse per frame (latches sprite_*, steps animation)
//   px_valid, px_x, px_y, bg_color : incoming pixel stream
//   sprite_x, sprite_y, sprite_en, anim_en : requested sprite state
//   vram_en, vram_addr : VRAM read request (registered)
//   vram_data     : VRAM registered read data (one cycle after the request)
//   pix_valid, pix_color, pix_hit : composited pixel, three cycles after input
module sprite_layer #(
    parameter int                SPRITE_W = 32,
    parameter int                SPRITE_H = 32,
    parameter int                FRAMES   = 4,
    parameter int                ANIM_DIV = 8,
    parameter int                CWIDTH   = 12,
    parameter int                XW       = 10,
    parameter int                YW       = 10,
    parameter logic [CWIDTH-1:0] KEY      = 12'hF0F,
    localparam int               AWIDTH   = $clog2(SPRITE_W * SPRITE_H * FRAMES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              px_valid,
    input  logic [XW-1:0]     px_x,
    input  logic [YW-1:0]     px_y,
    input  logic [CWIDTH-1:0] bg_color,
    input  logic [XW-1:0]     sprite_x,
    input  logic [YW-1:0]     sprite_y,
    input  logic              sprite_en,
    input  logic              anim_en,
    output logic              vram_en,
    output logic [AWIDTH-1:0] vram_addr,
    input  logic [CWIDTH-1:0] vram_data,
    output logic              pix_valid,
    output logic [CWIDTH-1:0] pix_color,
    output logic              pix_hit
);

    localparam int FW       = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int DW       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int FRAME_SZ = SPRITE_W * SPRITE_H;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(ANIM_DIV - 1);

    // Per-frame latched sprite state and animation counters
    logic [XW-1:0] lx_q, lx_d;
    logic [YW-1:0] ly_q, ly_d;
    logic          len_q, len_d;
    logic [DW-1:0] div_q, div_d;
    logic [FW-1:0] anim_q, anim_d;

    always_comb begin
        lx_d   = lx_q;
        ly_d   = ly_q;
        len_d  = len_q;
        div_d  = div_q;
        anim_d = anim_q;
        if (frame_start) begin
            lx_d  = sprite_x;
            ly_d  = sprite_y;
            len_d = sprite_en;
            if (anim_en) begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    anim_d = (anim_q == FRAME_LAST) ? '0 : anim_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lx_q   <= '0;
            ly_q   <= '0;
            len_q  <= 1'b0;
            div_q  <= '0;
            anim_q <= '0;
        end else begin
            lx_q   <= lx_d;
            ly_q   <= ly_d;
            len_q  <= len_d;
            div_q  <= div_d;
            anim_q <= anim_d;
        end
    end

    // ---- stage 0: hit test and address ----
    // Box end is computed one bit wider so a sprite hanging off the right or
    // bottom edge of the coordinate space does not wrap back to column 0.
    logic [XW:0]         x_end;
    logic [YW:0]         y_end;
    logic                in_box;
    logic [XW-1:0]       dx;
    logic [YW-1:0]       dy;
    logic [AWIDTH-1:0]   addr_s0;

    assign x_end = {1'b0, lx_q} + (XW + 1)'(SPRITE_W);
    assign y_end = {1'b0, ly_q} + (YW + 1)'(SPRITE_H);
    assign in_box = len_q & px_valid
                  & (px_x >= lx_q) & ({1'b0, px_x} < x_end)
                  & (px_y >= ly_q) & ({1'b0, px_y} < y_end);
    assign dx = px_x - lx_q;
    assign dy = px_y - ly_q;

    always_comb begin
        addr_s0 = '0;
        if (in_box) begin
            addr_s0 = AWIDTH'(32'(anim_q) * FRAME_SZ + 32'(dy) * SPRITE_W + 32'(dx));
        end
    end

    // ---- stage 1: VRAM request ----
    logic              vram_en_p1_q;
    logic [AWIDTH-1:0] vram_addr_p1_q;
    logic              vld_p1_q;
    logic [CWIDTH-1:0] bg_p1_q;
    // ---- stage 2: VRAM data returning ----
    logic              vld_p2_q;
    logic              hit_p2_q;
    logic [CWIDTH-1:0] bg_p2_q;
    // ---- stage 3: composited output ----
    logic              pix_valid_p3_q;
    logic              pix_hit_p3_q;
    logic [CWIDTH-1:0] pix_color_p3_q;

    logic              opaque;
    logic [CWIDTH-1:0] color_d;

    assign opaque = hit_p2_q & (vram_data != KEY);

    always_comb begin
        color_d = '0;
        if (vld_p2_q) begin
            color_d = opaque ? vram_data : bg_p2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vram_en_p1_q   <= 1'b0;
            vram_addr_p1_q <= '0;
            vld_p1_q       <= 1'b0;
            vld_p2_q       <= 1'b0;
            hit_p2_q       <= 1'b0;
            pix_valid_p3_q <= 1'b0;
            pix_hit_p3_q   <= 1'b0;
            pix_color_p3_q <= '0;
        end else begin
            vram_en_p1_q   <= in_box;
            vram_addr_p1_q <= addr_s0;
            vld_p1_q       <= px_valid;
            vld_p2_q       <= vld_p1_q;
            hit_p2_q       <= vram_en_p1_q;
            pix_valid_p3_q <= vld_p2_q;
            pix_hit_p3_q   <= opaque;
            pix_color_p3_q <= color_d;
        end
    end

    // Background colour only matters while its valid bit is set, so it is
    // carried without reset.
    always_ff @(posedge clk) begin
        bg_p1_q <= bg_color;
        bg_p2_q <= bg_p1_q;
    end

    assign vram_en   = vram_en_p1_q;
    assign vram_addr = vram_addr_p1_q;
    assign pix_valid = pix_valid_p3_q;
    assign pix_color = pix_color_p3_q;
    assign pix_hit   = pix_hit_p3_q;

endmodule

// File: tb/tb_sprite_layer.sv
// Testbench for sprite_layer: directed scenarios followed by randomized
// frames, with a reference model feeding two scoreboard queues (VRAM requests
// and composited pixels) that a separate monitor drains.
module tb_sprite_layer;

    localparam int SW  = 32;
    localparam int SH  = 32;
    localparam int FR  = 4;
    localparam int AD  = 2;
    localparam int CW  = 12;
    localparam int XW  = 10;
    localparam int YW  = 10;
    localparam logic [CW-1:0] KEY = 12'hF0F;
    localparam int AW  = 12;
    localparam int MEMSZ = SW * SH * FR;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          px_valid = 1'b0;
    logic [XW-1:0] px_x = '0;
    logic [YW-1:0] px_y = '0;
    logic [CW-1:0] bg_color = '0;
    logic [XW-1:0] sprite_x = '0;
    logic [YW-1:0] sprite_y = '0;
    logic          sprite_en = 1'b0;
    logic          anim_en = 1'b0;
    logic          vram_en;
    logic [AW-1:0] vram_addr;
    logic [CW-1:0] vram_data = '0;
    logic          pix_valid;
    logic [CW-1:0] pix_color;
    logic          pix_hit;

    sprite_layer #(
        .SPRITE_W(SW), .SPRITE_H(SH), .FRAMES(FR), .ANIM_DIV(AD),
        .CWIDTH(CW), .XW(XW), .YW(YW), .KEY(KEY)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .bg_color(bg_color),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
        .anim_en(anim_en), .vram_en(vram_en), .vram_addr(vram_addr),
        .vram_data(vram_data), .pix_valid(pix_valid), .pix_color(pix_color),
        .pix_hit(pix_hit)
    );

    always #5 clk = ~clk;

    // Sprite VRAM: registered read, zero when not enabled
    logic [CW-1:0] mem [0:MEMSZ-1];
    always @(posedge clk) vram_data <= vram_en ? mem[vram_addr] : '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [CW-1:0] color; logic hit; } pix_t;
    typedef struct { logic en; int addr; } vr_t;
    pix_t pq[$];
    vr_t  vq[$];

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    // Reference model state
    int m_lx = 0, m_ly = 0, m_len = 0, m_div = 0, m_frame = 0;
    // Requested sprite state, driven by step()
    int s_x = 0, s_y = 0, s_en = 0, s_aen = 0;

    // want: -1 use model, -2 expect a miss, >=0 expect a hit at that address
    task automatic step(input logic fs, input logic pv, input int x, input int y,
                        input logic [CW-1:0] bg, input int want);
        pix_t p;
        vr_t  v;
        int   hit;
        int   addr;
        @(negedge clk);
        rst = 1'b0;
        frame_start = fs;
        px_valid = pv;
        px_x = XW'(x);
        px_y = YW'(y);
        bg_color = bg;
        sprite_x = XW'(s_x);
        sprite_y = YW'(s_y);
        sprite_en = s_en[0];
        anim_en = s_aen[0];
        hit = (pv && m_len != 0 && x >= m_lx && x < m_lx + SW
               && y >= m_ly && y < m_ly + SH) ? 1 : 0;
        addr = hit ? (m_frame * SW * SH + (y - m_ly) * SW + (x - m_lx)) % MEMSZ : 0;
        if (pv && want >= 0) begin
            hit = 1;
            addr = want;
        end else if (want == -2) begin
            hit = 0;
            addr = 0;
        end
        v.en = (hit != 0);
        v.addr = addr;
        vq.push_back(v);
        if (pv) begin
            p.cyc = cyc;
            p.hit = (hit != 0) && (mem[addr] != KEY);
            p.color = p.hit ? mem[addr] : bg;
            pq.push_back(p);
        end
        if (fs) begin
            m_lx = s_x;
            m_ly = s_y;
            m_len = s_en;
            if (s_aen != 0) begin
                m_div = m_div + 1;
                if (m_div == AD) begin
                    m_div = 0;
                    m_frame = (m_frame + 1) % FR;
                end
            end
        end
    endtask

    task automatic do_rst(input logic fs);
        vr_t v;
        @(negedge clk);
        rst = 1'b1;
        frame_start = fs;
        px_valid = 1'b1;
        sprite_en = 1'b1;
        anim_en = 1'b1;
        v.en = 1'b0;
        v.addr = 0;
        vq.push_back(v);
        // Pixels issued in the two cycles before reset never reach the output
        while (pq.size() > 0 && pq[$].cyc >= cyc - 2) void'(pq.pop_back());
        m_lx = 0; m_ly = 0; m_len = 0; m_div = 0; m_frame = 0;
    endtask

    // Monitor / scoreboard
    initial begin
        vr_t  v;
        pix_t p;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            if (vq.size() > 0) begin
                v = vq.pop_front();
                checks++;
                if (vram_en !== v.en || vram_addr !== AW'(v.addr)) begin
                    errors++;
                    $display("FAIL vram cyc=%0d got en=%0b addr=%0d want en=%0b addr=%0d",
                             cyc, vram_en, vram_addr, v.en, v.addr);
                end
            end
            checks++;
            if (pix_valid === 1'b1) begin
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL pix_unexpected cyc=%0d got color=%h hit=%0b want no pixel",
                             cyc, pix_color, pix_hit);
                end else begin
                    p = pq.pop_front();
                    if (p.cyc + 3 != cyc || pix_color !== p.color || pix_hit !== p.hit) begin
                        errors++;
                        $display("FAIL pix cyc=%0d got color=%h hit=%0b want color=%h hit=%0b issued=%0d",
                                 cyc, pix_color, pix_hit, p.color, p.hit, p.cyc);
                    end
                end
            end else if (pix_valid !== 1'b0 || pix_color !== '0 || pix_hit !== 1'b0) begin
                errors++;
                $display("FAIL pix_idle cyc=%0d got valid=%b color=%h hit=%b want 0/000/0",
                         cyc, pix_valid, pix_color, pix_hit);
            end
        end
    end

    initial begin
        int r;
        for (int i = 0; i < MEMSZ; i++) begin
            r = $urandom;
            mem[i] = (i % 7 == 3) ? KEY : CW'(r);
        end
        mem[0] = 12'hABC;
        mem[1] = KEY;

        repeat (2) @(negedge clk);
        do_rst(1'b0);
        mon_en = 1'b1;
        do_rst(1'b0);

        // Latch and hit, boundaries
        s_x = 100; s_y = 50; s_en = 1; s_aen = 0;
        step(1'b1, 1'b0, 0, 0, 12'h000, -1);
        step(1'b0, 1'b1, 100, 50, 12'h00F, 0);
        step(1'b0, 1'b1, 101, 50, 12'h00F, 1);
        step(1'b0, 1'b1, 131, 81, 12'h00F, 1023);
        step(1'b0, 1'b1, 132, 50, 12'h00F, -2);
        step(1'b0, 1'b1, 99, 50, 12'h00F, -2);
        step(1'b0, 1'b1, 100, 82, 12'h00F, -2);
        step(1'b0, 1'b1, 100, 49, 12'h00F, -2);

        // Tear-free update
        s_x = 200;
        step(1'b0, 1'b1, 100, 50, 12'h00F, 0);
        step(1'b0, 1'b1, 200, 50, 12'h00F, -2);
        step(1'b1, 1'b0, 0, 0, 12'h000, -1);
        step(1'b0, 1'b1, 200, 50, 12'h00F, 0);
        step(1'b0, 1'b1, 100, 50, 12'h00F, -2);

        // Pixel alongside frame_start uses the old position
        s_x = 300;
        step(1'b1, 1'b1, 200, 50, 12'h00F, 0);
        step(1'b0, 1'b1, 300, 50, 12'h00F, 0);
        step(1'b0, 1'b1, 200, 50, 12'h00F, -2);

        // Animation: page advances every second enabled frame
        s_aen = 1;
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 1'b0, 0, 0, 12'h000, -1);
            step(1'b0, 1'b1, 300, 50, 12'h00F, ((i / 2) % 4) * 1024);
        end
        s_aen = 0;
        repeat (3) begin
            step(1'b1, 1'b0, 0, 0, 12'h000, -1);
            step(1'b0, 1'b1, 300, 50, 12'h00F, 0);
        end
        s_aen = 1;
        step(1'b1, 1'b0, 0, 0, 12'h000, -1);
        step(1'b0, 1'b1, 300, 50, 12'h00F, 1024);

        // Edge of coordinate range
        s_aen = 0; s_x = 1010; s_y = 50;
        step(1'b1, 1'b0, 0, 0, 12'h000, -1);
        step(1'b0, 1'b1, 1023, 50, 12'h123, 1024 + 13);
        step(1'b0, 1'b1, 5, 50, 12'h123, -2);
        step(1'b0, 1'b1, 1009, 50, 12'h123, -2);
        step(1'b0, 1'b1, 1010, 81, 12'h123, 1024 + 31 * 32);

        // Reset mid-stream, with frame_start asserted during reset
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1010 + i, 50 + i, 12'h456, -1);
        do_rst(1'b1);
        step(1'b0, 1'b1, 1010, 50, 12'h456, -2);
        step(1'b0, 1'b1, 0, 0, 12'h456, -2);
        step(1'b1, 1'b1, 1010, 50, 12'h456, -2);
        step(1'b0, 1'b1, 1010, 50, 12'h456, 0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            s_x = $urandom_range(0, 1023);
            s_y = $urandom_range(0, 1023);
            s_en = ($urandom_range(0, 3) != 0) ? 1 : 0;
            s_aen = $urandom_range(0, 1);
            step(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), CW'($urandom), -1);
            for (int k = 0; k < 50; k++) begin
                if ($urandom_range(0, 9) == 0) s_x = $urandom_range(0, 1023);
                if ($urandom_range(0, 149) == 0) begin
                    do_rst(1'($urandom_range(0, 1)));
                end else begin
                    step(1'b0, 1'($urandom_range(0, 3) != 0),
                         (m_lx + $urandom_range(0, 40) + 1020) % 1024,
                         (m_ly + $urandom_range(0, 40) + 1020) % 1024,
                         CW'($urandom), -1);
                end
            end
        end

        repeat (5) step(1'b0, 1'b0, 0, 0, 12'h000, -1);
        @(posedge clk);
        #2;
        checks++;
        if (pq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending pixels want 0", pq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_layer.md
# sprite_layer

Pixel-pipeline compositing stage that drives one read port of the sprite VRAM and consumes its registered read data. For each active pixel, it tests the pixel against a rectangular sprite box and issues the VRAM fetch. It then replaces the incoming background colour with the fetched sprite texel unless that texel equals the transparency key. Position and enable are latched once per frame to prevent tearing, and an internal counter steps through animation frames stored back-to-back in VRAM.

## Interface
Parameters:
- SPRITE_W, 32, sprite width in pixels
- SPRITE_H, 32, sprite height in pixels
- FRAMES, 4, animation frames stored consecutively in VRAM
- ANIM_DIV, 8, video frames per animation step (≥1)
- CWIDTH, 12, colour width; must equal the VRAM WIDTH
- XW, 10, pixel x coordinate width
- YW, 10, pixel y coordinate width
- KEY, 12'hF0F, transparent texel value
- AWIDTH (localparam), $clog2(SPRITE_W*SPRITE_H*FRAMES)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of each frame, asserted during blanking
- px_valid  in  1  active-video qualifier for px_x/px_y/bg_color
- px_x  in  XW  current pixel x
- px_y  in  YW  current pixel y
- bg_color  in  CWIDTH  colour from the previous layer
- sprite_x  in  XW  requested top-left x
- sprite_y  in  YW  requested top-left y
- sprite_en  in  1  requested sprite visibility
- anim_en  in  1  enables animation stepping
- vram_en  out  1  VRAM port enable
- vram_addr  out  AWIDTH  VRAM port address
- vram_data  in  CWIDTH  VRAM registered read data, one cycle after vram_en/vram_addr
- pix_valid  out  1  output pixel qualifier
- pix_color  out  CWIDTH  composited colour
- pix_hit  out  1  opaque sprite texel was drawn

## Operation
- Frame latch: on any cycle with frame_start=1, register sprite_x, sprite_y and sprite_en into lx, ly and len. All hit tests use only the latched values. A pixel presented in the same cycle as frame_start uses the pre-update values.
- Animation:
  - A div counter (0..ANIM_DIV-1) increments on each frame_start while anim_en=1.
  - On wrap, anim_frame increments, and wraps from FRAMES-1 to 0.
  - anim_en=0 holds both counters.
  - Animation updates at the same edge as the latch.
- Hit test (stage 0, combinational):
  - in_box = len & px_valid & (px_x ≥ lx) & (px_x < lx+SPRITE_W) & (py ≥ ly) & (py < ly+SPRITE_H).
  - The sums are computed at XW+1 / YW+1 bits, so boxes that extend past the coordinate range never wrap.
- Address: anim_frame*SPRITE_W*SPRITE_H + (py−ly)*SPRITE_W + (px−lx), truncated to AWIDTH.
- Stage 1 (registered): vram_en=in_box and vram_addr. When in_box=0, vram_addr=0. px_valid and bg_color are delayed alongside, with no bubbles.
- Stage 2: the VRAM presents vram_data. The VRAM returns 0 when not enabled. The block delays bg_color, px_valid and the hit flag one more stage.
- Stage 3 (registered output):
  - opaque = hit_d2 & (vram_data ≠ KEY).
  - pix_color = opaque ? vram_data : bg_d2.
  - pix_hit = opaque.
  - pix_valid = valid_d2.
  - A non-valid slot produces pix_color=0 and pix_hit=0.

## Timing
- Fully pipelined, one pixel per cycle, no stalls.
- A pixel presented at cycle t produces vram_en/vram_addr at t+1 and pix_* at t+3.
- Reset values:
  - vram_en=0, vram_addr=0.
  - pix_valid=0, pix_color=0, pix_hit=0.
  - lx=ly=0, len=0, anim_frame=0, div=0.
  - All pipeline valid/hit registers are 0.
- rst overrides frame_start in the same cycle.
- Reset mid-frame: in-flight pixels are discarded and outputs read 0 from the next cycle. The sprite stays hidden until a frame_start with sprite_en=1.
- ANIM_DIV=1: anim_frame steps on every enabled frame_start.
- Boundary pixels: px_x=lx and px_x=lx+SPRITE_W−1 hit; px_x=lx+SPRITE_W misses. The same rule applies in y.

## Test plan
- Latch and hit:
  - Stimulus: SPRITE_W=H=32; frame_start with sprite_x=100, sprite_y=50, en=1; pixel (100,50) at cycle t.
  - Response: vram_en=1 and vram_addr=0 at t+1; pixel (131,81) gives addr 1023; pixel (132,50) gives vram_en=0.
- Compositing:
  - Stimulus: bg_color=12'h00F.
  - Response: texel 12'hABC gives pix_color=12'hABC and pix_hit=1 at t+3; texel 12'hF0F (KEY) gives pix_color=12'h00F and pix_hit=0.
- Tear-free update:
  - Stimulus: change sprite_x mid-frame from 100 to 200.
  - Response: pixel (100,50) still hits until the next frame_start; afterwards (200,50) hits and (100,50) misses.
- Animation:
  - Stimulus: ANIM_DIV=2, anim_en=1, 8 frame_starts.
  - Response: anim_frame sequence 0,0,1,1,2,2,3,3, then 0. Pixel (lx,ly) in frame 1 gives addr 1024. anim_en=0 freezes the sequence.
- Edge of range:
  - Stimulus: sprite_x=1010 with XW=10.
  - Response: pixel 1023 hits with addr column 13; pixel 5 misses.
- Reset mid-stream:
  - Stimulus: rst during a stream of hitting pixels.
  - Response: pix_valid=0 and vram_en=0 the next cycle; no hits until a frame_start with en=1.
